// File: rtl/result_drain_pkg.sv
// Shared definitions for the systolic-array result path: default array
// geometry and the drain FSM states, so array, feeder and drain agree.
package result_drain_pkg;

  localparam int DEFAULT_N = 4;
  localparam int DEFAULT_W = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/result_drain_shadow_bank.sv
// Shadow copy of the PE accumulators: parallel load of all N*N results,
// combinational read of one element by row-major index.
module shadow_bank
  import result_drain_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = DEFAULT_W
) (
  input  logic                     clk,
  input  logic                     load,
  input  logic [N*N*W-1:0]         load_data,
  input  logic [$clog2(N*N)-1:0]   rd_idx,
  output logic [W-1:0]             rd_data
);

  logic [W-1:0] bank_q [N*N];
  logic [W-1:0] bank_d [N*N];

  always_comb begin
    for (int k = 0; k < N*N; k++) begin
      bank_d[k] = load ? load_data[k*W +: W] : bank_q[k];
    end
  end

  // No reset: contents are only observable after a capture has loaded them.
  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

  assign rd_data = bank_q[rd_idx];

endmodule

// File: rtl/result_drain.sv
// Captures the systolic array's accumulators on start, clears the array,
// and streams the captured results out one element per valid/ready beat.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int N = DEFAULT_N,
  parameter int W = DEFAULT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N*N*W-1:0]         acc_in,
  output logic                     clear_out,
  output logic                     busy,
  output logic [W-1:0]             out_data,
  output logic [$clog2(N*N)-1:0]   out_index,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     dropped
);

  localparam int             IW       = $clog2(N*N);
  localparam logic [IW-1:0]  LAST_IDX = IW'(N*N-1);

  drain_state_e  state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          clear_q, clear_d;
  logic          dropped_q, dropped_d;
  logic          draining, at_last, xfer, accept;
  logic [W-1:0]  shadow_data;

  // A new capture is taken when idle, or back-to-back on the final beat.
  always_comb begin
    draining  = (state_q == DRAIN);
    at_last   = (idx_q == LAST_IDX);
    xfer      = draining && out_ready;
    accept    = start && (!draining || (xfer && at_last));
    state_d   = state_q;
    idx_d     = idx_q;
    clear_d   = accept;
    dropped_d = dropped_q | (start & ~accept);
    if (accept) begin
      state_d = DRAIN;
      idx_d   = '0;
    end else if (xfer) begin
      if (at_last) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      clear_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      clear_q   <= clear_d;
      dropped_q <= dropped_d;
    end
  end

  shadow_bank #(
    .N (N),
    .W (W)
  ) u_shadow_bank (
    .clk       (clk),
    .load      (accept && !rst),
    .load_data (acc_in),
    .rd_idx    (idx_q),
    .rd_data   (shadow_data)
  );

  assign clear_out = clear_q;
  assign busy      = draining;
  assign out_valid = draining;
  assign out_last  = draining && at_last;
  assign out_index = draining ? idx_q : '0;
  assign out_data  = draining ? shadow_data : '0;
  assign dropped   = dropped_q;

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: a table of directed vectors, a few
// hand-written corner sequences, then random traffic against a queue model.
module tb_result_drain;
  import result_drain_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int NN = N*N;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             out_ready = 1'b0;
  logic [NN*W-1:0]  acc_in = '0;
  logic             clear_out, busy, out_valid, out_last, dropped;
  logic [W-1:0]     out_data;
  logic [3:0]       out_index;

  int checks = 0;
  int errors = 0;

  // Reference model: a capture becomes a queue of pending beats.
  logic [W-1:0] m_q[$];
  bit           m_clear = 1'b0;
  bit           m_dropped = 1'b0;

  typedef struct {
    bit         rst, start, ready;
    logic [7:0] base;
    bit         v;
    logic [3:0] idx;
    logic [7:0] data;
    bit         last, clr, busy, drop;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  result_drain #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .acc_in    (acc_in),
    .clear_out (clear_out),
    .busy      (busy),
    .out_data  (out_data),
    .out_index (out_index),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .dropped   (dropped)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic loadAcc(input int base);
    for (int k = 0; k < NN; k++) acc_in[k*W +: W] = W'(base + k);
  endtask

  task automatic randAcc();
    for (int k = 0; k < NN; k++) acc_in[k*W +: W] = W'($urandom);
  endtask

  task automatic modelUpdate();
    bit xfer, take;
    if (rst) begin
      m_q.delete();
      m_clear   = 1'b0;
      m_dropped = 1'b0;
    end else begin
      xfer = (m_q.size() > 0) && out_ready;
      take = start && (m_q.size() == 0 || (xfer && m_q.size() == 1));
      if (start && !take) m_dropped = 1'b1;
      m_clear = take;
      if (xfer) void'(m_q.pop_front());
      if (take) begin
        m_q.delete();
        for (int k = 0; k < NN; k++) m_q.push_back(acc_in[k*W +: W]);
      end
    end
  endtask

  task automatic compareModel();
    int sz;
    sz = m_q.size();
    checkOutput("valid", 32'(out_valid), 32'(sz > 0));
    checkOutput("busy", 32'(busy), 32'(sz > 0));
    checkOutput("last", 32'(out_last), 32'(sz == 1));
    checkOutput("clear", 32'(clear_out), 32'(m_clear));
    checkOutput("dropped", 32'(dropped), 32'(m_dropped));
    if (sz > 0) begin
      checkOutput("index", 32'(out_index), 32'(NN - sz));
      checkOutput("data", 32'(out_data), 32'(m_q[0]));
    end else begin
      checkOutput("index", 32'(out_index), 32'd0);
      checkOutput("data", 32'(out_data), 32'd0);
    end
  endtask

  // One clock: drive inputs, clock them in, advance the model, compare.
  task automatic applyStimulus(input bit r, input bit s, input bit rdy);
    rst       = r;
    start     = s;
    out_ready = rdy;
    @(posedge clk);
    modelUpdate();
    #1;
    compareModel();
  endtask

  initial begin
    int budget;
    int beats;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h01, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 8'h01, 1'b1, 4'd0, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 4'd1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 4'd1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 4'd1, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 4'd2, 8'h03, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h50, 1'b1, 4'd3, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h50, 1'b1, 4'd4, 8'h05, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h50, 1'b1, 4'd5, 8'h06, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h50, 1'b1, 4'd5, 8'h06, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h50, 1'b1, 4'd6, 8'h07, 1'b0, 1'b0, 1'b1, 1'b1};

    for (int i = 0; i < 11; i++) begin
      loadAcc(int'(vecs[i].base));
      applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].ready);
      checkOutput($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].v));
      checkOutput($sformatf("vec%0d_index", i), 32'(out_index), 32'(vecs[i].idx));
      checkOutput($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].data));
      checkOutput($sformatf("vec%0d_last", i), 32'(out_last), 32'(vecs[i].last));
      checkOutput($sformatf("vec%0d_clear", i), 32'(clear_out), 32'(vecs[i].clr));
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      checkOutput($sformatf("vec%0d_dropped", i), 32'(dropped), 32'(vecs[i].drop));
    end

    // Finish the first drain up to the final beat.
    budget = 0;
    while (out_index != 4'd15 && budget < 20) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      budget++;
    end
    checkOutput("reach_idx15", 32'(out_index), 32'd15);
    checkOutput("idx15_data", 32'(out_data), 32'h10);
    checkOutput("idx15_last", 32'(out_last), 32'd1);

    // Back-to-back capture on the final transfer.
    loadAcc(8'hA0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("b2b_index", 32'(out_index), 32'd0);
    checkOutput("b2b_data", 32'(out_data), 32'hA0);
    checkOutput("b2b_clear", 32'(clear_out), 32'd1);
    checkOutput("b2b_busy", 32'(busy), 32'd1);
    loadAcc(8'h33);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("b2b_clear_drop", 32'(clear_out), 32'd0);
    checkOutput("b2b_data1", 32'(out_data), 32'hA1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("pre_rst_index", 32'(out_index), 32'd7);
    checkOutput("pre_rst_data", 32'(out_data), 32'hA7);

    // Reset mid-drain wins over a simultaneous start.
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_dropped", 32'(dropped), 32'd0);
    checkOutput("rst_clear", 32'(clear_out), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);

    loadAcc(1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("restart_data", 32'(out_data), 32'h01);
    checkOutput("restart_index", 32'(out_index), 32'd0);
    budget = 0;
    beats  = 0;
    while (out_valid && budget < 40) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      beats++;
      budget++;
    end
    checkOutput("restart_beats", 32'(beats), 32'd16);
    checkOutput("restart_idle", 32'(busy), 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3) == 0) randAcc();
      applyStimulus($urandom_range(63) == 0, $urandom_range(5) == 0, $urandom_range(2) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
